// File: rtl/leaf_gpu_ingress_queue_if.sv
// Handshake bundle between a GPU, its ingress queue and the leaf router input port.
//   gpu_wr_*      : GPU -> queue flit offer (data, valid, dest) and queue -> GPU ready
//   out_*         : queue -> router head flit (data, dest, valid) and router -> queue ready
// master: the GPU/router side; slave: the queue itself.
interface leaf_gpu_ingress_queue_if #(
    parameter int unsigned DWIDTH = 16
) ();
    logic [DWIDTH-1:0] gpu_wr_data;
    logic              gpu_wr_valid;
    logic [5:0]        gpu_wr_dest;
    logic              gpu_wr_ready;
    logic [DWIDTH-1:0] out_data;
    logic [5:0]        out_dest_addr;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output gpu_wr_data, gpu_wr_valid, gpu_wr_dest, out_ready,
        input  gpu_wr_ready, out_data, out_dest_addr, out_valid
    );

    modport slave (
        input  gpu_wr_data, gpu_wr_valid, gpu_wr_dest, out_ready,
        output gpu_wr_ready, out_data, out_dest_addr, out_valid
    );
endinterface

// File: rtl/leaf_gpu_ingress_queue.sv
// GPU-side ingress queue for a leaf router. Buffers {dest, data} flits in a
// circular buffer, presents the head show-ahead to the router, applies
// backpressure to the GPU and drops flits addressed to this leaf.
//   clk, reset   : clock, asynchronous active-low reset
//   bus (slave)  : GPU write handshake and router head handshake
//   arb_enable   : router arbitration enable; masks out_valid when low
//   flush        : synchronous clear of the queue (priority over push/pop)
//   fifo_full/fifo_empty/fifo_count : occupancy status
//   drop_count   : saturating count of self-addressed flits dropped
module leaf_gpu_ingress_queue #(
    parameter int unsigned DWIDTH     = 16,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [3:0]  GROUP_ID   = 4'b1000,
    parameter int unsigned ROUTER_ID  = 3
) (
    input  logic                                 clk,
    input  logic                                 reset,
    leaf_gpu_ingress_queue_if.slave              bus,
    input  logic                                 arb_enable,
    input  logic                                 flush,
    output logic                                 fifo_full,
    output logic                                 fifo_empty,
    output logic [$clog2(FIFO_DEPTH):0]          fifo_count,
    output logic [7:0]                           drop_count
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned EW = DWIDTH + 6;
    localparam logic [5:0]  SELF_ADDR = {GROUP_ID, 2'(ROUTER_ID)};

    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    drop_q, drop_d;

    logic          accept, push, drop, pop;
    logic [EW-1:0] head;

    // Status is derived from the registered count only.
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign fifo_count = count_q;
    assign drop_count = drop_q;

    assign bus.gpu_wr_ready = !fifo_full;

    // Show-ahead head presentation.
    assign head              = mem_q[rd_ptr_q];
    assign bus.out_data      = head[DWIDTH-1:0];
    assign bus.out_dest_addr = head[EW-1:DWIDTH];
    assign bus.out_valid     = !fifo_empty && arb_enable;

    assign accept = bus.gpu_wr_valid && !fifo_full && !flush;
    assign push   = accept && (bus.gpu_wr_dest != SELF_ADDR);
    assign drop   = accept && (bus.gpu_wr_dest == SELF_ADDR);
    assign pop    = bus.out_valid && bus.out_ready && !flush;

    // Next-state for pointers, occupancy and drop counter.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        drop_d   = drop_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
            if (drop && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {bus.gpu_wr_dest, bus.gpu_wr_data};
    end
endmodule

// File: tb/tb_leaf_gpu_ingress_queue.sv
module tb_leaf_gpu_ingress_queue;
    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 8;
    localparam logic [5:0]  SELF  = 6'h23;

    logic       clk;
    logic       reset;
    logic       arb_enable;
    logic       flush;
    logic       fifo_full;
    logic       fifo_empty;
    logic [3:0] fifo_count;
    logic [7:0] drop_count;

    leaf_gpu_ingress_queue_if #(.DWIDTH(DW)) bus ();

    leaf_gpu_ingress_queue #(
        .DWIDTH(DW), .FIFO_DEPTH(DEPTH), .GROUP_ID(4'b1000), .ROUTER_ID(3)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus), .arb_enable(arb_enable),
        .flush(flush), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .fifo_count(fifo_count), .drop_count(drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [21:0] sb[$];
    int mdrop = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: compare at the falling edge, update the model, advance.
    task automatic step();
        logic        mready;
        logic [21:0] e;
        @(negedge clk);
        mready = (sb.size() != DEPTH);
        chk("count", 32'(fifo_count), 32'(sb.size()));
        chk("full",  32'(fifo_full), 32'(sb.size() == DEPTH));
        chk("empty", 32'(fifo_empty), 32'(sb.size() == 0));
        chk("ready", 32'(bus.gpu_wr_ready), 32'(mready));
        chk("valid", 32'(bus.out_valid), 32'((sb.size() != 0) && arb_enable));
        chk("drops", 32'(drop_count), 32'(mdrop));
        if (!flush && arb_enable && bus.out_ready && sb.size() != 0) begin
            e = sb.pop_front();
            chk("data", 32'(bus.out_data), 32'(e[15:0]));
            chk("dest", 32'(bus.out_dest_addr), 32'(e[21:16]));
        end
        if (!flush && bus.gpu_wr_valid && mready) begin
            if (bus.gpu_wr_dest == SELF) begin
                if (mdrop < 255) mdrop++;
            end else begin
                sb.push_back({bus.gpu_wr_dest, bus.gpu_wr_data});
            end
        end
        if (flush) sb.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic [15:0] d, input logic [5:0] a);
        bus.gpu_wr_valid = v;
        bus.gpu_wr_data  = d;
        bus.gpu_wr_dest  = a;
    endtask

    task automatic reset_vals(input string tag);
        chk({tag, "_count"}, 32'(fifo_count), 32'd0);
        chk({tag, "_empty"}, 32'(fifo_empty), 32'd1);
        chk({tag, "_full"},  32'(fifo_full),  32'd0);
        chk({tag, "_ready"}, 32'(bus.gpu_wr_ready), 32'd1);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_drop"},  32'(drop_count), 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        arb_enable = 1'b1;
        flush = 1'b0;
        bus.out_ready = 1'b0;
        offer(1'b0, 16'h0, 6'h0);
        #1;
        reset_vals("rst");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Basic in-order transfer, one cycle latency.
        bus.out_ready = 1'b1;
        offer(1'b1, 16'hA001, 6'h05); step();
        offer(1'b1, 16'hA002, 6'h09); step();
        offer(1'b1, 16'hA003, 6'h11); step();
        offer(1'b0, 16'h0, 6'h0);
        step(); step();
        chk("basic_end_count", 32'(fifo_count), 32'd0);

        // Fill and backpressure.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            offer(1'b1, 16'hB000 + 16'(i), 6'h10 + 6'(i));
            step();
        end
        chk("fill_full", 32'(fifo_full), 32'd1);
        chk("fill_ready", 32'(bus.gpu_wr_ready), 32'd0);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("bp_count7", 32'(fifo_count), 32'd7);
        chk("bp_ready1", 32'(bus.gpu_wr_ready), 32'd1);
        step();
        chk("bp_refull", 32'(fifo_count), 32'd8);
        offer(1'b0, 16'h0, 6'h0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) step();

        // Self-address drop and saturation.
        offer(1'b1, 16'hC001, 6'h23); step();
        offer(1'b1, 16'hC002, 6'h22); bus.out_ready = 1'b0; step();
        offer(1'b0, 16'h0, 6'h0);
        chk("drop_one", 32'(drop_count), 32'd1);
        chk("drop_cnt1", 32'(fifo_count), 32'd1);
        bus.out_ready = 1'b1;
        step();
        for (int i = 0; i < 300; i++) begin
            offer(1'b1, 16'(i), SELF);
            step();
        end
        offer(1'b0, 16'h0, 6'h0);
        chk("drop_sat", 32'(drop_count), 32'd255);

        // Simultaneous push/pop at count 4 across pointer wrap.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            offer(1'b1, 16'hD000 + 16'(i), 6'h01); step();
        end
        bus.out_ready = 1'b1;
        for (int i = 4; i < 24; i++) begin
            offer(1'b1, 16'hD000 + 16'(i), 6'(i)); step();
        end
        chk("pp_count4", 32'(fifo_count), 32'd4);
        offer(1'b0, 16'h0, 6'h0);
        for (int i = 0; i < 5; i++) step();

        // arb_enable gating.
        arb_enable = 1'b0;
        offer(1'b1, 16'hE001, 6'h31); step();
        offer(1'b1, 16'hE002, 6'h32); step();
        offer(1'b0, 16'h0, 6'h0);
        step(); step();
        chk("arb_hold", 32'(fifo_count), 32'd2);
        arb_enable = 1'b1;
        step(); step();
        chk("arb_drain", 32'(fifo_count), 32'd0);

        // Flush with concurrent push and pop.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            offer(1'b1, 16'hF000 + 16'(i), 6'h02); step();
        end
        flush = 1'b1;
        bus.out_ready = 1'b1;
        offer(1'b1, 16'hF0FF, 6'h02);
        step();
        flush = 1'b0;
        offer(1'b0, 16'h0, 6'h0);
        chk("flush_count", 32'(fifo_count), 32'd0);
        chk("flush_drop", 32'(drop_count), 32'd255);
        step();

        // Asynchronous reset mid-cycle with 3 queued.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            offer(1'b1, 16'h1230 + 16'(i), 6'h07); step();
        end
        offer(1'b0, 16'h0, 6'h0);
        #2;
        reset = 1'b0;
        #1;
        reset_vals("async");
        reset = 1'b1;
        sb.delete();
        mdrop = 0;
        bus.out_ready = 1'b1;
        offer(1'b1, 16'h4242, 6'h15); step();
        offer(1'b0, 16'h0, 6'h0);
        step(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
